// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the load/store data memory.
// Byte lanes are little-endian: lane i holds word bits [8*i+7:8*i].
package data_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 4'b0001 << addr_lo;
      SIZE_H:  return addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data so any enabled lane sees its byte.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_B:  return {4{wdata[7:0]}};
      SIZE_H:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr_lo,
                                              input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SIZE_H:  return is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response handshake bundle between the datapath and the data memory.
interface data_memory_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ram.sv
// DEPTH x 32 synchronous RAM with byte-lane write enables and a registered read port.
module data_mem_ram #(
  parameter int unsigned DEPTH = 128
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store data memory controller: one outstanding access, READ_LAT-cycle response,
// error response for illegal size, misalignment or out-of-range word index.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  data_memory_ctrl_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept, misalign, oor, req_err;
  logic        write_q, unsigned_q, err_q;
  logic [1:0]  size_q, addr_lo_q;
  logic [31:0] ram_rdata;

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign misalign = ((bus.req_size == SIZE_H) && bus.req_addr[0]) ||
                    ((bus.req_size == SIZE_W) && (bus.req_addr[1:0] != 2'b00));
  assign oor      = (bus.req_addr >> 2) >= ADDR_W'(DEPTH);
  assign req_err  = (bus.req_size == SIZE_X) || misalign || oor;

  data_mem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (accept && bus.req_write && !req_err),
    .re_i    (accept && !bus.req_write && !req_err),
    .be_i    (byte_en(bus.req_size, bus.req_addr[1:0])),
    .addr_i  (bus.req_addr[IdxW+1:2]),
    .wdata_i (store_align(bus.req_size, bus.req_wdata)),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (READ_LAT <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(READ_LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request attributes needed to shape the response once the RAM data lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_lo_q  <= 2'b00;
    end else if (accept) begin
      write_q    <= bus.req_write;
      unsigned_q <= bus.req_unsigned;
      err_q      <= req_err;
      size_q     <= bus.req_size;
      addr_lo_q  <= bus.req_addr[1:0];
    end
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    unique case (state_q)
      IDLE: bus.req_ready = 1'b1;
      WAIT: ;
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = (err_q || write_q) ? '0
                                           : load_extend(ram_rdata, size_q, addr_lo_q, unsigned_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Three controllers (READ_LAT 1, 3, 4) driven by directed accesses; a byte-array model
// predicts handshake and response every cycle, and each access also has a literal expectation.
module tb_data_memory_ctrl;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 32;
  localparam int LATS [3] = '{1, 3, 4};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        vld [3];
  logic        rrdy[3];
  logic        wr, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wd;
  logic        rdy [3];
  logic        rv  [3];
  logic        rerr[3];
  logic [31:0] rdat[3];

  data_memory_ctrl_if #(.ADDR_W(AW)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].req_valid    = vld[g];
    assign bus[g].req_write    = wr;
    assign bus[g].req_size     = sz;
    assign bus[g].req_unsigned = uns;
    assign bus[g].req_addr     = addr;
    assign bus[g].req_wdata    = wd;
    assign bus[g].rsp_ready    = rrdy[g];
    assign rdy[g]  = bus[g].req_ready;
    assign rv[g]   = bus[g].rsp_valid;
    assign rerr[g] = bus[g].rsp_err;
    assign rdat[g] = bus[g].rsp_rdata;

    data_memory_ctrl #(
      .DEPTH    (DEPTH),
      .ADDR_W   (AW),
      .READ_LAT (LATS[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[g])
    );
  end

  // Model: byte-addressed memory plus "cycles since acceptance" per controller.
  logic [7:0]  mem_m [3][4*DEPTH];
  logic        busy  [3] = '{1'b0, 1'b0, 1'b0};
  int          age   [3] = '{0, 0, 0};
  logic [31:0] exp_d [3];
  logic        exp_e [3];

  function automatic logic pred_err(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
           ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] pred_load(input int d, input logic [1:0] s, input logic u,
                                            input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << s;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[d][int'(a) + i]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        busy[d] <= 1'b0;
        age[d]  <= 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (!busy[d]) begin
          if (vld[d]) begin
            busy[d] <= 1'b1;
            age[d]  <= 1;
            if (pred_err(sz, addr)) begin
              exp_d[d] <= 32'h0;
              exp_e[d] <= 1'b1;
            end else begin
              exp_e[d] <= 1'b0;
              if (wr) begin
                exp_d[d] <= 32'h0;
                for (int i = 0; i < (1 << sz); i++) mem_m[d][int'(addr) + i] <= wd[8*i +: 8];
              end else begin
                exp_d[d] <= pred_load(d, sz, uns, addr);
              end
            end
          end
        end else if (age[d] >= LATS[d]) begin
          if (rrdy[d]) busy[d] <= 1'b0;
        end else begin
          age[d] <= age[d] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic ev;
      ev = busy[d] && (age[d] >= LATS[d]);
      chk($sformatf("model_req_ready[%0d]", d), 32'(rdy[d]), 32'(!busy[d]));
      chk($sformatf("model_rsp_valid[%0d]", d), 32'(rv[d]), 32'(ev));
      if (ev) begin
        chk($sformatf("model_rsp_rdata[%0d]", d), rdat[d], exp_d[d]);
        chk($sformatf("model_rsp_err[%0d]", d), 32'(rerr[d]), 32'(exp_e[d]));
      end
    end
  end

  task automatic access(input int d, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] data, input int hold,
                        input logic [31:0] xd, input logic xe, input string name);
    int n;
    @(negedge clk);
    wr = w; sz = s; uns = u; addr = a; wd = data;
    vld[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vld[d] = 1'b0;
      chk({name, "_accept_timeout"}, 32'(rdy[d]), 32'd1);
      return;
    end
    @(posedge clk);
    #1 vld[d] = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rv[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n + 1), 32'(LATS[d]));
    if (n >= 20) return;
    repeat (hold) @(negedge clk);
    chk({name, "_rdata"}, rdat[d], xd);
    chk({name, "_err"}, 32'(rerr[d]), 32'(xe));
    rrdy[d] = 1'b1;
    @(posedge clk);
    #1 rrdy[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr = 1'b0; uns = 1'b0; sz = 2'd0; addr = 32'h0; wd = 32'h0;
    for (int d = 0; d < 3; d++) begin
      vld[d]  = 1'b0;
      rrdy[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_req_ready", 32'(rdy[d]), 32'd1);
      chk("reset_rsp_valid", 32'(rv[d]), 32'd0);
      chk("reset_rsp_rdata", rdat[d], 32'h0);
      chk("reset_rsp_err", 32'(rerr[d]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // READ_LAT = 1
    access(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, "st_w_10");
    access(0, 0, 2'd2, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0, "ld_w_10");
    access(0, 0, 2'd0, 1, 32'h12, 32'h0,        0, 32'h000000AD, 0, "ld_bu_12");
    access(0, 0, 2'd1, 0, 32'h10, 32'h0,        0, 32'hFFFFBEEF, 0, "ld_h_10");
    access(0, 0, 2'd1, 1, 32'h12, 32'h0,        0, 32'h0000DEAD, 0, "ld_hu_12");
    access(0, 0, 2'd2, 0, 32'h11, 32'h0,        0, 32'h0,        1, "ld_w_misal");
    access(0, 1, 2'd2, 0, 32'h20, 32'h0,        0, 32'h0,        0, "st_w_20");
    access(0, 1, 2'd0, 0, 32'h21, 32'h12345680, 0, 32'h0,        0, "st_b_21");
    access(0, 0, 2'd0, 0, 32'h21, 32'h0,        0, 32'hFFFFFF80, 0, "ld_b_21");
    access(0, 0, 2'd0, 1, 32'h21, 32'h0,        0, 32'h00000080, 0, "ld_bu_21");
    access(0, 0, 2'd2, 0, 32'h20, 32'h0,        0, 32'h00008000, 0, "ld_w_20");
    access(0, 1, 2'd2, 0, 32'h30, 32'h11112222, 0, 32'h0,        0, "st_w_30");
    access(0, 1, 2'd1, 0, 32'h32, 32'hAAAA8001, 0, 32'h0,        0, "st_h_32");
    access(0, 0, 2'd1, 0, 32'h32, 32'h0,        0, 32'hFFFF8001, 0, "ld_h_32");
    access(0, 0, 2'd1, 0, 32'h33, 32'h0,        0, 32'h0,        1, "ld_h_33");
    access(0, 1, 2'd1, 0, 32'h33, 32'hBEEF,     0, 32'h0,        1, "st_h_33");
    access(0, 0, 2'd2, 0, 32'h30, 32'h0,        0, 32'h80012222, 0, "ld_w_30");
    access(0, 1, 2'd2, 0, 32'h0,  32'h12345678, 0, 32'h0,        0, "st_w_0");
    access(0, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 0, 32'h0,        1, "st_w_oor");
    access(0, 0, 2'd0, 0, 32'h40, 32'h0,        0, 32'h0,        1, "ld_b_oor");
    access(0, 1, 2'd3, 0, 32'h0,  32'hFFFFFFFF, 0, 32'h0,        1, "st_x_0");
    access(0, 0, 2'd3, 0, 32'h0,  32'h0,        0, 32'h0,        1, "ld_x_0");
    access(0, 0, 2'd2, 0, 32'h0,  32'h0,        0, 32'h12345678, 0, "ld_w_0");

    // READ_LAT = 3, response held for 5 cycles
    access(1, 1, 2'd2, 0, 32'h4, 32'hA5A5A5A5, 0, 32'h0,        0, "l3_st_w_4");
    access(1, 0, 2'd2, 0, 32'h4, 32'h0,        5, 32'hA5A5A5A5, 0, "l3_ld_w_4");

    // READ_LAT = 4, reset during WAIT
    access(2, 1, 2'd2, 0, 32'h8, 32'h0BADF00D, 0, 32'h0, 0, "l4_st_w_8");
    @(negedge clk);
    wr = 1'b0; sz = 2'd2; addr = 32'h8;
    chk("l4_pre_ready", 32'(rdy[2]), 32'd1);
    vld[2] = 1'b1;
    @(posedge clk);
    #1 vld[2] = 1'b0;
    @(negedge clk);
    chk("l4_wait_ready", 32'(rdy[2]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("l4_rst_req_ready", 32'(rdy[2]), 32'd1);
    chk("l4_rst_rsp_valid", 32'(rv[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("l4_no_rsp_after_rst", 32'(rv[2]), 32'd0);
    end
    access(2, 0, 2'd2, 0, 32'h8, 32'h0, 0, 32'h0BADF00D, 0, "l4_ld_w_8");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
